// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the PC sequencer slice.
//   - XLEN            : datapath width
//   - RESET_VECTOR_DEF: default PC after reset
//   - TRAP_VECTOR_DEF : default PC of the misaligned-target trap handler
//   - seq_state_e     : sequencer state encoding (BOOT, RUN)
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/rv_target_gen.sv
// rv_target_gen: combinational control-transfer target selection.
// Ports:
//   pc_i, imm_i, rs1_i     : current PC, sign-extended immediate, JALR base
//   is_branch_i, brq_i     : B-type instruction and its comparator result
//   is_jal_i, is_jalr_i    : jump decodes (JALR has priority over JAL)
//   next_target_o          : transfer target when taken, else pc+4
//   taken_o                : a control transfer is taken this cycle
//   misaligned_o           : taken transfer whose target is not word aligned
module rv_target_gen
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            is_branch_i,
  input  logic            brq_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  output logic [XLEN-1:0] next_target_o,
  output logic            taken_o,
  output logic            misaligned_o
);

  localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] WORD      = XLEN'(4);

  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] xfer_tgt;

  always_comb begin
    // JALR clears bit 0 before the alignment test, so only bit 1 can fault.
    jalr_tgt      = (rs1_i + imm_i) & LSB_CLEAR;
    rel_tgt       = pc_i + imm_i;
    taken_o       = is_jal_i | is_jalr_i | (is_branch_i & brq_i);
    xfer_tgt      = is_jalr_i ? jalr_tgt : rel_tgt;
    // A not-taken branch never faults, whatever its offset.
    misaligned_o  = taken_o && (xfer_tgt[1:0] != 2'b00);
    next_target_o = taken_o ? xfer_tgt : (pc_i + WORD);
  end

endmodule

// File: rtl/rv_pc_sequencer.sv
// rv_pc_sequencer: program-counter sequencer for the single-cycle core.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   stall              : freeze PC, trap CSRs and counters for this cycle
//   is_branch, brq     : B-type decode and comparator result
//   is_jal, is_jalr    : jump decodes
//   is_mret            : return from trap (highest priority)
//   imm, rs1           : immediate and JALR base
//   pc, pc_plus4       : registered PC and combinational link value
//   redirect, trap     : registered one-cycle event pulses
//   mepc, mtval        : faulting PC and offending target of the last trap
//   instret            : retired-instruction counter
//   br_taken_cnt       : taken B-type counter
// After reset the sequencer spends one BOOT cycle with the PC held, then
// advances once per non-stalled RUN cycle.
module rv_pc_sequencer
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             brq,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             is_mret,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             redirect,
  output logic             trap,
  output logic [31:0]      mepc,
  output logic [31:0]      mtval,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] br_taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e       state_q;
  logic [31:0]      pc_q;
  logic             redirect_q;
  logic             trap_q;
  logic [31:0]      mepc_q;
  logic [31:0]      mtval_q;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] br_taken_cnt_q;

  logic [31:0]      xfer_target;
  logic             xfer_taken;
  logic             xfer_misaligned;

  logic [31:0]      pc_d;
  logic             trap_d;
  logic             br_count_d;

  rv_target_gen u_target_gen (
    .pc_i          (pc_q),
    .imm_i         (imm),
    .rs1_i         (rs1),
    .is_branch_i   (is_branch),
    .brq_i         (brq),
    .is_jal_i      (is_jal),
    .is_jalr_i     (is_jalr),
    .next_target_o (xfer_target),
    .taken_o       (xfer_taken),
    .misaligned_o  (xfer_misaligned)
  );

  assign pc_plus4 = pc_q + 32'd4;

  // Next PC for a RUN cycle, in priority order: MRET, trap, transfer, +4.
  always_comb begin
    pc_d       = pc_plus4;
    trap_d     = 1'b0;
    br_count_d = 1'b0;
    if (is_mret) begin
      pc_d = mepc_q;
    end else if (xfer_misaligned) begin
      pc_d   = TRAP_VECTOR;
      trap_d = 1'b1;
    end else if (xfer_taken) begin
      pc_d = xfer_target;
      // Only a taken branch that is not shadowed by a jump is counted.
      br_count_d = is_branch && brq && !is_jal && !is_jalr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_VECTOR;
      redirect_q     <= 1'b0;
      trap_q         <= 1'b0;
      mepc_q         <= 32'h0;
      mtval_q        <= 32'h0;
      instret_q      <= '0;
      br_taken_cnt_q <= '0;
    end else if (stall) begin
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          redirect_q <= 1'b0;
          trap_q     <= 1'b0;
        end
        ST_RUN: begin
          pc_q       <= pc_d;
          // Any flow change that lands somewhere other than pc+4.
          redirect_q <= (pc_d != pc_plus4);
          trap_q     <= trap_d;
          if (trap_d) begin
            mepc_q  <= pc_q;
            mtval_q <= xfer_target;
          end else begin
            instret_q <= instret_q + CNT_ONE;
          end
          if (br_count_d) begin
            br_taken_cnt_q <= br_taken_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign redirect     = redirect_q;
  assign trap         = trap_q;
  assign mepc         = mepc_q;
  assign mtval        = mtval_q;
  assign instret      = instret_q;
  assign br_taken_cnt = br_taken_cnt_q;

endmodule

// File: tb/tb_rv_pc_sequencer.sv
// Bench for rv_pc_sequencer: directed scenarios followed by random control
// traffic. The driver steps a reference model per cycle and queues the
// expected post-edge outputs; the monitor pops one entry per cycle after
// the rising edge and compares every output field.
module tb_rv_pc_sequencer;

  localparam int W = 5 * 32 + 2;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        is_branch;
  logic        brq;
  logic        is_jal;
  logic        is_jalr;
  logic        is_mret;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        trap;
  logic [31:0] mepc;
  logic [31:0] mtval;
  logic [31:0] instret;
  logic [31:0] br_taken_cnt;

  rv_pc_sequencer #(
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .CNT_W        (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .is_branch    (is_branch),
    .brq          (brq),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .is_mret      (is_mret),
    .imm          (imm),
    .rs1          (rs1),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect),
    .trap         (trap),
    .mepc         (mepc),
    .mtval        (mtval),
    .instret      (instret),
    .br_taken_cnt (br_taken_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1; stall = 1'b0; is_branch = 1'b0; brq = 1'b0;
    is_jal = 1'b0; is_jalr = 1'b0; is_mret = 1'b0; imm = '0; rs1 = '0;
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_mepc, m_mtval, m_instret, m_br;
  logic        m_redir, m_trap, m_boot;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // One clock of architectural behaviour, written from the rules directly.
  task automatic model_step(input logic r, st, br, q, jl, jr, mr,
                            input logic [31:0] im, rs);
    logic [31:0] seq, tgt, nxt;
    logic taken;
    if (r) begin
      m_pc = RV; m_mepc = 0; m_mtval = 0; m_instret = 0; m_br = 0;
      m_redir = 0; m_trap = 0; m_boot = 1;
    end else if (st) begin
      m_redir = 0; m_trap = 0;
    end else if (m_boot) begin
      m_boot = 0; m_redir = 0; m_trap = 0;
    end else begin
      seq   = m_pc + 4;
      taken = jl || jr || (br && q);
      tgt   = jr ? ((rs + im) & 32'hFFFF_FFFE) : (m_pc + im);
      m_trap = 0;
      if (mr) begin
        nxt = m_mepc;
        m_instret++;
      end else if (taken && (tgt % 4 != 0)) begin
        nxt = TV; m_mepc = m_pc; m_mtval = tgt; m_trap = 1;
      end else if (taken) begin
        nxt = tgt;
        m_instret++;
        if (!jl && !jr) m_br++;
      end else begin
        nxt = seq;
        m_instret++;
      end
      m_redir = (nxt != seq);
      m_pc = nxt;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, st, br, q, jl, jr, mr,
                       input logic [31:0] im, rs);
    @(negedge clk);
    rst = r; stall = st; is_branch = br; brq = q;
    is_jal = jl; is_jalr = jr; is_mret = mr; imm = im; rs1 = rs;
    model_step(r, st, br, q, jl, jr, mr, im, rs);
    exp_q.push_back({m_pc, m_mepc, m_mtval, m_instret, m_br, m_redir, m_trap});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);  // BOOT cycle
  endtask

  // JAL to an aligned absolute address from the model's current PC.
  task automatic goto(input logic [31:0] addr);
    drive(0, 0, 0, 0, 1, 0, 0, addr - m_pc, 32'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    logic [31:0] e_pc;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_pc = e[161:130];
        chk("pc",           pc,                e_pc);
        chk("pc_plus4",     pc_plus4,          e_pc + 32'd4);
        chk("mepc",         mepc,              e[129:98]);
        chk("mtval",        mtval,             e[97:66]);
        chk("instret",      instret,           e[65:34]);
        chk("br_taken_cnt", br_taken_cnt,      e[33:2]);
        chk("redirect",     {31'b0, redirect}, {31'b0, e[1]});
        chk("trap",         {31'b0, trap},     {31'b0, e[0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r_imm;
    int sel;

    // Reset then idle: pc 0, 0 (BOOT), 4, 8 and instret 2.
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(3);

    // Taken and not-taken branch from 0x20 with imm -8.
    goto(32'h20);
    drive(0, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);
    goto(32'h20);
    drive(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);

    // JALR to 0x103 -> 0x102 traps; MRET back to 0x40; JALR 0x101 -> 0x100.
    goto(32'h40);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h103);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h101);

    // Branch with imm 6: not taken goes sequential, taken traps.
    goto(32'h80);
    drive(0, 0, 1, 0, 0, 0, 0, 32'h6, 32'h0);
    drive(0, 0, 1, 1, 0, 0, 0, 32'h6, 32'h0);

    // Stalled JAL for 4 cycles, then it takes effect.
    goto(32'h60);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 1, 0, 0, 32'h10, 32'h0);
    drive(0, 0, 0, 0, 1, 0, 0, 32'h10, 32'h0);

    // Illegal JAL+JALR: JALR wins.
    drive(0, 0, 0, 0, 1, 1, 0, 32'h8, 32'h200);

    // Reset during a stall.
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 0, 0, 1, 0, 0, 32'h40, 32'h0);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);  // stall holds BOOT
    idle(3);

    // Random control traffic.
    for (int i = 0; i < 400; i++) begin
      sel   = $urandom_range(0, 9);
      r_imm = $urandom_range(0, 255) - 128;
      if ($urandom_range(0, 3) == 0) r_imm = r_imm & 32'hFFFF_FFFC;
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 7) == 0),
            (sel <= 3), $urandom_range(0, 1),
            (sel == 4 || sel == 9), (sel == 5 || sel == 9),
            (sel == 6),
            r_imm, $urandom);
    end

    idle(2);
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
